// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Default width and FSM state encodings.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor used by the serial datapath.
// Produces difference and borrow-out from a, b and borrow-in.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Y,
  output logic Bout
);

  assign Y    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per enabled cycle.
// Result and borrow are published one cycle after the last bit.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bflop;
  logic             d;
  logic             bout;

  full_subtractor u_fs (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (bflop),
    .Y    (d),
    .Bout (bout)
  );

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (cnt == LAST) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      bflop  <= 1'b0;
      done   <= 1'b0;
      Y      <= '0;
      borrow <= 1'b0;
    end else begin
      // done is a single-cycle pulse; never held across a stall
      done  <= 1'b0;
      state <= state_nxt;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              a_sh  <= A;
              b_sh  <= B;
              res   <= '0;
              cnt   <= '0;
              bflop <= 1'b0;
            end
          end
          RUN: begin
            res   <= {d, res[WIDTH-1:1]};
            bflop <= bout;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CW'(1);
          end
          DONE: begin
            Y      <= res;
            borrow <= bflop;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
